// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, FSM state
// encodings, datapath select codes and the instruction classes from decode.
package cpu_defs_pkg;

  localparam int OPW    = 6;
  localparam int ALUOPW = 3;

  localparam logic [OPW-1:0] OP_ADD   = 6'b000000;
  localparam logic [OPW-1:0] OP_SUB   = 6'b000001;
  localparam logic [OPW-1:0] OP_ADDIU = 6'b000010;
  localparam logic [OPW-1:0] OP_AND   = 6'b010000;
  localparam logic [OPW-1:0] OP_ANDI  = 6'b010001;
  localparam logic [OPW-1:0] OP_ORI   = 6'b010010;
  localparam logic [OPW-1:0] OP_SLL   = 6'b011000;
  localparam logic [OPW-1:0] OP_SLTI  = 6'b011100;
  localparam logic [OPW-1:0] OP_SW    = 6'b100110;
  localparam logic [OPW-1:0] OP_LW    = 6'b100111;
  localparam logic [OPW-1:0] OP_BEQ   = 6'b110000;
  localparam logic [OPW-1:0] OP_BNE   = 6'b110001;
  localparam logic [OPW-1:0] OP_J     = 6'b111000;
  localparam logic [OPW-1:0] OP_JR    = 6'b111001;
  localparam logic [OPW-1:0] OP_JAL   = 6'b111010;
  localparam logic [OPW-1:0] OP_HALT  = 6'b111111;

  typedef enum logic [2:0] {
    ST_IF     = 3'b000,
    ST_ID     = 3'b001,
    ST_EXE_LS = 3'b010,
    ST_MEM    = 3'b011,
    ST_WB_LD  = 3'b100,
    ST_EXE_BR = 3'b101,
    ST_EXE_AL = 3'b110,
    ST_WB_AL  = 3'b111
  } state_e;

  localparam logic [ALUOPW-1:0] ALU_ADD = 3'b000;
  localparam logic [ALUOPW-1:0] ALU_SUB = 3'b001;
  localparam logic [ALUOPW-1:0] ALU_SLL = 3'b010;
  localparam logic [ALUOPW-1:0] ALU_OR  = 3'b011;
  localparam logic [ALUOPW-1:0] ALU_AND = 3'b100;
  localparam logic [ALUOPW-1:0] ALU_SLT = 3'b110;

  localparam logic [1:0] PCSRC_PC4    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_RS     = 2'b10;
  localparam logic [1:0] PCSRC_JUMP   = 2'b11;

  localparam logic [1:0] REGDST_RA = 2'b00;
  localparam logic [1:0] REGDST_RT = 2'b01;
  localparam logic [1:0] REGDST_RD = 2'b10;

  typedef enum logic [3:0] {
    CLS_ALU,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_BNE,
    CLS_J,
    CLS_JR,
    CLS_JAL,
    CLS_HALT,
    CLS_UNDEF
  } instr_class_e;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control bus between the control unit (master) and the multi-cycle datapath
// (slave): opcode/zero feedback in, every datapath strobe out.
interface multicycle_control_unit_if #(
  parameter int OPW    = cpu_defs_pkg::OPW,
  parameter int ALUOPW = cpu_defs_pkg::ALUOPW
);
  logic [OPW-1:0]    Opcode;
  logic              zero;
  logic              PCWre;
  logic              IRWre;
  logic              RegWre;
  logic [1:0]        RegDst;
  logic              WrRegDSrc;
  logic              DBDataSrc;
  logic              ALUSrcA;
  logic              ALUSrcB;
  logic              ExtSel;
  logic [ALUOPW-1:0] ALUOp;
  logic [1:0]        PCSrc;
  logic              mRD;
  logic              mWR;
  logic [2:0]        state;

  modport master (
    input  Opcode, zero,
    output PCWre, IRWre, RegWre, RegDst, WrRegDSrc, DBDataSrc,
           ALUSrcA, ALUSrcB, ExtSel, ALUOp, PCSrc, mRD, mWR, state
  );

  modport slave (
    output Opcode, zero,
    input  PCWre, IRWre, RegWre, RegDst, WrRegDSrc, DBDataSrc,
           ALUSrcA, ALUSrcB, ExtSel, ALUOp, PCSrc, mRD, mWR, state
  );
endinterface

// File: rtl/multicycle_control_unit_decode.sv
// cu_decode: purely combinational opcode decode into the static ALU controls,
// write-back register class and instruction class used by the sequencing FSM.
module cu_decode
  import cpu_defs_pkg::*;
(
  input  logic [OPW-1:0]    opcode,
  output logic [ALUOPW-1:0] alu_op,
  output logic              alu_src_a,
  output logic              alu_src_b,
  output logic              ext_sel,
  output logic [1:0]        reg_dst_wb,
  output instr_class_e      instr_class
);

  // R-type ALU ops write rd; immediate forms write rt and take the extended imm.
  always_comb begin
    alu_op      = ALU_ADD;
    alu_src_a   = 1'b0;
    alu_src_b   = 1'b0;
    ext_sel     = 1'b1;
    reg_dst_wb  = REGDST_RD;
    instr_class = CLS_UNDEF;
    case (opcode)
      OP_ADD:   instr_class = CLS_ALU;
      OP_SUB: begin
        alu_op      = ALU_SUB;
        instr_class = CLS_ALU;
      end
      OP_ADDIU: begin
        alu_src_b   = 1'b1;
        reg_dst_wb  = REGDST_RT;
        instr_class = CLS_ALU;
      end
      OP_AND: begin
        alu_op      = ALU_AND;
        instr_class = CLS_ALU;
      end
      OP_ANDI: begin
        alu_op      = ALU_AND;
        alu_src_b   = 1'b1;
        ext_sel     = 1'b0;
        reg_dst_wb  = REGDST_RT;
        instr_class = CLS_ALU;
      end
      OP_ORI: begin
        alu_op      = ALU_OR;
        alu_src_b   = 1'b1;
        ext_sel     = 1'b0;
        reg_dst_wb  = REGDST_RT;
        instr_class = CLS_ALU;
      end
      OP_SLL: begin
        alu_op      = ALU_SLL;
        alu_src_a   = 1'b1;
        instr_class = CLS_ALU;
      end
      OP_SLTI: begin
        alu_op      = ALU_SLT;
        alu_src_b   = 1'b1;
        reg_dst_wb  = REGDST_RT;
        instr_class = CLS_ALU;
      end
      OP_SW: begin
        alu_src_b   = 1'b1;
        instr_class = CLS_SW;
      end
      OP_LW: begin
        alu_src_b   = 1'b1;
        instr_class = CLS_LW;
      end
      OP_BEQ: begin
        alu_op      = ALU_SUB;
        instr_class = CLS_BEQ;
      end
      OP_BNE: begin
        alu_op      = ALU_SUB;
        instr_class = CLS_BNE;
      end
      OP_J:     instr_class = CLS_J;
      OP_JR:    instr_class = CLS_JR;
      OP_JAL:   instr_class = CLS_JAL;
      OP_HALT:  instr_class = CLS_HALT;
      default:  instr_class = CLS_UNDEF;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle CPU control FSM: sequences IF/ID/EXE/MEM/WB and gates strobes.
// Optional retired-instruction counter enabled by defining CU_RETIRE_COUNT_EN.
module multicycle_control_unit
  import cpu_defs_pkg::*;
(
  input  logic CLK,
  input  logic Reset,
`ifdef CU_RETIRE_COUNT_EN
  output logic [31:0] RetireCount,
`endif
  multicycle_control_unit_if.master bus
);

  state_e state_q, state_d;

  logic [ALUOPW-1:0] dec_alu_op;
  logic              dec_alu_src_a;
  logic              dec_alu_src_b;
  logic              dec_ext_sel;
  logic [1:0]        dec_reg_dst_wb;
  instr_class_e      dec_class;

  logic              pc_wre, ir_wre, reg_wre, wr_reg_d_src, db_data_src;
  logic              alu_src_a, alu_src_b, ext_sel, m_rd, m_wr;
  logic [1:0]        reg_dst, pc_src;
  logic [ALUOPW-1:0] alu_op;

  cu_decode u_decode (
    .opcode      (bus.Opcode),
    .alu_op      (dec_alu_op),
    .alu_src_a   (dec_alu_src_a),
    .alu_src_b   (dec_alu_src_b),
    .ext_sel     (dec_ext_sel),
    .reg_dst_wb  (dec_reg_dst_wb),
    .instr_class (dec_class)
  );

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state_q <= ST_IF;
    else        state_q <= state_d;
  end

  // ALU controls come straight from decode from ID onward; IF keeps them idle.
  always_comb begin
    state_d      = ST_IF;
    pc_wre       = 1'b0;
    ir_wre       = 1'b0;
    reg_wre      = 1'b0;
    reg_dst      = REGDST_RA;
    wr_reg_d_src = 1'b1;
    db_data_src  = 1'b0;
    pc_src       = PCSRC_PC4;
    m_rd         = 1'b0;
    m_wr         = 1'b0;
    alu_op       = (state_q == ST_IF) ? ALU_ADD : dec_alu_op;
    alu_src_a    = (state_q == ST_IF) ? 1'b0 : dec_alu_src_a;
    alu_src_b    = (state_q == ST_IF) ? 1'b0 : dec_alu_src_b;
    ext_sel      = (state_q == ST_IF) ? 1'b0 : dec_ext_sel;
    case (state_q)
      ST_IF: begin
        ir_wre  = 1'b1;
        state_d = ST_ID;
      end
      ST_ID: begin
        case (dec_class)
          CLS_J: begin
            pc_wre = 1'b1;
            pc_src = PCSRC_JUMP;
          end
          CLS_JR: begin
            pc_wre = 1'b1;
            pc_src = PCSRC_RS;
          end
          CLS_JAL: begin
            pc_wre       = 1'b1;
            pc_src       = PCSRC_JUMP;
            reg_wre      = 1'b1;
            reg_dst      = REGDST_RA;
            wr_reg_d_src = 1'b0;
          end
          CLS_HALT:          state_d = ST_ID;
          CLS_BEQ, CLS_BNE:  state_d = ST_EXE_BR;
          CLS_LW, CLS_SW:    state_d = ST_EXE_LS;
          CLS_ALU:           state_d = ST_EXE_AL;
          default:           pc_wre  = 1'b1;
        endcase
      end
      ST_EXE_AL: state_d = ST_WB_AL;
      ST_WB_AL: begin
        reg_wre      = 1'b1;
        reg_dst      = dec_reg_dst_wb;
        wr_reg_d_src = 1'b1;
        db_data_src  = 1'b0;
        pc_wre       = 1'b1;
      end
      ST_EXE_BR: begin
        pc_wre = 1'b1;
        if ((dec_class == CLS_BEQ && bus.zero) || (dec_class == CLS_BNE && !bus.zero))
          pc_src = PCSRC_BRANCH;
      end
      ST_EXE_LS: state_d = ST_MEM;
      ST_MEM: begin
        if (dec_class == CLS_LW) begin
          m_rd    = 1'b1;
          state_d = ST_WB_LD;
        end else begin
          m_wr   = (dec_class == CLS_SW);
          pc_wre = 1'b1;
        end
      end
      ST_WB_LD: begin
        reg_wre      = 1'b1;
        reg_dst      = REGDST_RT;
        db_data_src  = 1'b1;
        wr_reg_d_src = 1'b1;
        pc_wre       = 1'b1;
      end
      default: state_d = ST_IF;
    endcase
  end

  assign bus.PCWre     = pc_wre;
  assign bus.IRWre     = ir_wre;
  assign bus.RegWre    = reg_wre;
  assign bus.RegDst    = reg_dst;
  assign bus.WrRegDSrc = wr_reg_d_src;
  assign bus.DBDataSrc = db_data_src;
  assign bus.ALUSrcA   = alu_src_a;
  assign bus.ALUSrcB   = alu_src_b;
  assign bus.ExtSel    = ext_sel;
  assign bus.ALUOp     = alu_op;
  assign bus.PCSrc     = pc_src;
  assign bus.mRD       = m_rd;
  assign bus.mWR       = m_wr;
  assign bus.state     = state_q;

`ifdef CU_RETIRE_COUNT_EN
  logic [31:0] retire_count_q, retire_count_d;

  always_comb begin
    retire_count_d = retire_count_q + {31'b0, pc_wre};
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) retire_count_q <= 32'h0;
    else        retire_count_q <= retire_count_d;
  end

  assign RetireCount = retire_count_q;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: per-cycle expected strobes are
// queued per instruction and compared on the falling edge.
module tb_multicycle_control_unit;
  import cpu_defs_pkg::*;

  typedef struct {
    string      name;
    logic [2:0] st;
    logic       pcw, irw, rw, wrs, dbs, mrd, mwr, srca, srcb, ext;
    logic [1:0] rdst, pcs;
    logic [2:0] aluop;
    bit         alu_chk, rst_chk;
  } exp_t;

  logic CLK;
  logic Reset;
  int   vec_count;
  int   err_count;
  exp_t exp_q[$];

  multicycle_control_unit_if bus ();

`ifdef CU_RETIRE_COUNT_EN
  logic [31:0] retire_count;
  multicycle_control_unit dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .RetireCount (retire_count),
    .bus         (bus)
  );
`else
  multicycle_control_unit dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );
`endif

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_count++;
    if (obs !== exp) begin
      err_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mkExp(input string name, input logic [2:0] st);
    exp_t e;
    e.name = name; e.st = st;
    e.pcw = 0; e.irw = 0; e.rw = 0; e.wrs = 0; e.dbs = 0; e.mrd = 0; e.mwr = 0;
    e.srca = 0; e.srcb = 0; e.ext = 0; e.rdst = 2'b00; e.pcs = 2'b00; e.aluop = 3'b000;
    e.alu_chk = 0; e.rst_chk = 0;
    return e;
  endfunction

  task automatic checkCycle();
    exp_t e;
    if (exp_q.size() == 0) begin
      checkOutput("scoreboard.empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    checkOutput({e.name, ".state"},  32'(bus.state),  32'(e.st));
    checkOutput({e.name, ".PCWre"},  32'(bus.PCWre),  32'(e.pcw));
    checkOutput({e.name, ".IRWre"},  32'(bus.IRWre),  32'(e.irw));
    checkOutput({e.name, ".RegWre"}, 32'(bus.RegWre), 32'(e.rw));
    checkOutput({e.name, ".mRD"},    32'(bus.mRD),    32'(e.mrd));
    checkOutput({e.name, ".mWR"},    32'(bus.mWR),    32'(e.mwr));
    if (e.rw || e.rst_chk) checkOutput({e.name, ".RegDst"}, 32'(bus.RegDst), 32'(e.rdst));
    if (e.rw) begin
      checkOutput({e.name, ".WrRegDSrc"}, 32'(bus.WrRegDSrc), 32'(e.wrs));
      checkOutput({e.name, ".DBDataSrc"}, 32'(bus.DBDataSrc), 32'(e.dbs));
    end
    if (e.pcw || e.rst_chk) checkOutput({e.name, ".PCSrc"}, 32'(bus.PCSrc), 32'(e.pcs));
    if (e.alu_chk || e.rst_chk) checkOutput({e.name, ".ALUOp"}, 32'(bus.ALUOp), 32'(e.aluop));
    if (e.alu_chk) begin
      checkOutput({e.name, ".ALUSrcA"}, 32'(bus.ALUSrcA), 32'(e.srca));
      checkOutput({e.name, ".ALUSrcB"}, 32'(bus.ALUSrcB), 32'(e.srcb));
      checkOutput({e.name, ".ExtSel"},  32'(bus.ExtSel),  32'(e.ext));
    end
  endtask

  task automatic stepCycle();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Expected per-cycle behaviour of one instruction, written from the opcode table.
  task automatic pushInstr(input logic [5:0] op, input logic z, input string name);
    exp_t e;
    logic [2:0] aop;
    logic a, b, x, rtype;
    aop = 3'b000; a = 0; b = 0; x = 1; rtype = 1;
    case (op)
      6'b000001: aop = 3'b001;
      6'b000010: begin b = 1; rtype = 0; end
      6'b010000: aop = 3'b100;
      6'b010001: begin aop = 3'b100; b = 1; x = 0; rtype = 0; end
      6'b010010: begin aop = 3'b011; b = 1; x = 0; rtype = 0; end
      6'b011000: begin aop = 3'b010; a = 1; end
      6'b011100: begin aop = 3'b110; b = 1; rtype = 0; end
      6'b100110, 6'b100111: b = 1;
      6'b110000, 6'b110001: aop = 3'b001;
      default: ;
    endcase
    e = mkExp({name, ".IF"}, 3'b000); e.irw = 1; exp_q.push_back(e);
    e = mkExp({name, ".ID"}, 3'b001);
    case (op)
      6'b111000: begin e.pcw = 1; e.pcs = 2'b11; exp_q.push_back(e); end
      6'b111001: begin e.pcw = 1; e.pcs = 2'b10; exp_q.push_back(e); end
      6'b111010: begin
        e.pcw = 1; e.pcs = 2'b11; e.rw = 1; e.rdst = 2'b00; e.wrs = 0;
        exp_q.push_back(e);
      end
      6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001, 6'b010010,
      6'b011000, 6'b011100, 6'b100110, 6'b100111, 6'b110000, 6'b110001: begin
        e.alu_chk = 1; e.aluop = aop; e.srca = a; e.srcb = b; e.ext = x;
        exp_q.push_back(e);
        if (op == 6'b110000 || op == 6'b110001) begin
          e.name = {name, ".EXE_BR"}; e.st = 3'b101; e.pcw = 1;
          e.pcs = ((op == 6'b110000) == z) ? 2'b01 : 2'b00;
          exp_q.push_back(e);
        end else if (op == 6'b100110 || op == 6'b100111) begin
          e.name = {name, ".EXE_LS"}; e.st = 3'b010; exp_q.push_back(e);
          e.name = {name, ".MEM"}; e.st = 3'b011;
          if (op == 6'b100110) begin
            e.mwr = 1; e.pcw = 1; e.pcs = 2'b00; exp_q.push_back(e);
          end else begin
            e.mrd = 1; exp_q.push_back(e);
            e.name = {name, ".WB_LD"}; e.st = 3'b100; e.mrd = 0;
            e.rw = 1; e.rdst = 2'b01; e.dbs = 1; e.wrs = 1; e.pcw = 1; e.pcs = 2'b00;
            exp_q.push_back(e);
          end
        end else begin
          e.name = {name, ".EXE_AL"}; e.st = 3'b110; exp_q.push_back(e);
          e.name = {name, ".WB_AL"}; e.st = 3'b111; e.rw = 1;
          e.rdst = rtype ? 2'b10 : 2'b01; e.wrs = 1; e.dbs = 0; e.pcw = 1; e.pcs = 2'b00;
          exp_q.push_back(e);
        end
      end
      default: begin e.pcw = 1; e.pcs = 2'b00; exp_q.push_back(e); end
    endcase
  endtask

  task automatic runQueue(input bit final_step);
    checkCycle();
    while (exp_q.size() > 0) begin
      stepCycle();
      checkCycle();
    end
    if (final_step) stepCycle();
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic z, input string name);
    bus.Opcode = op;
    bus.zero   = z;
    pushInstr(op, z, name);
    runQueue(1'b1);
  endtask

  // Asynchronous reset mid-cycle, then release on a falling edge back in IF.
  task automatic asyncReset(input string name);
    exp_t e;
    #2 Reset = 1'b0;
    #1;
    e = mkExp(name, 3'b000); e.irw = 1; e.rst_chk = 1;
    exp_q.push_back(e);
    checkCycle();
    @(posedge CLK);
    @(negedge CLK);
    Reset = 1'b1;
  endtask

  initial begin
    exp_t e;
    vec_count = 0;
    err_count = 0;
    Reset = 1'b0;
    bus.Opcode = OP_ADD;
    bus.zero = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    e = mkExp("reset", 3'b000); e.irw = 1; e.rst_chk = 1;
    exp_q.push_back(e);
    checkCycle();
    Reset = 1'b1;
`ifdef CU_RETIRE_COUNT_EN
    checkOutput("retire.after_reset", retire_count, 32'd0);
`endif
    applyStimulus(OP_ADD, 1'b0, "add0");
    applyStimulus(OP_ADD, 1'b0, "add1");
    applyStimulus(OP_ADD, 1'b0, "add2");
`ifdef CU_RETIRE_COUNT_EN
    checkOutput("retire.three_add", retire_count, 32'd3);
`endif
    applyStimulus(OP_SUB,   1'b0, "sub");
    applyStimulus(OP_ADDIU, 1'b0, "addiu");
    applyStimulus(OP_AND,   1'b0, "and");
    applyStimulus(OP_ANDI,  1'b0, "andi");
    applyStimulus(OP_ORI,   1'b0, "ori");
    applyStimulus(OP_SLL,   1'b0, "sll");
    applyStimulus(OP_SLTI,  1'b1, "slti");
    applyStimulus(OP_LW,    1'b0, "lw");
    applyStimulus(OP_SW,    1'b0, "sw");
    applyStimulus(OP_BEQ,   1'b1, "beq_taken");
    applyStimulus(OP_BEQ,   1'b0, "beq_not");
    applyStimulus(OP_BNE,   1'b0, "bne_taken");
    applyStimulus(OP_BNE,   1'b1, "bne_not");
    applyStimulus(OP_J,     1'b0, "j");
    applyStimulus(OP_JR,    1'b0, "jr");
    applyStimulus(OP_JAL,   1'b0, "jal");
    applyStimulus(6'b000011, 1'b0, "undef");

    bus.Opcode = OP_HALT;
    e = mkExp("halt.IF", 3'b000); e.irw = 1; exp_q.push_back(e);
    checkCycle();
    for (int i = 0; i < 10; i++) begin
      stepCycle();
      e = mkExp($sformatf("halt.ID%0d", i), 3'b001); exp_q.push_back(e);
      checkCycle();
    end
    asyncReset("halt.reset");

    bus.Opcode = OP_SW;
    pushInstr(OP_SW, 1'b0, "sw_rst");
    exp_q.pop_back();
    e = mkExp("sw_rst.MEM", 3'b011); e.mwr = 1; e.pcw = 1; e.pcs = 2'b00;
    e.alu_chk = 1; e.srcb = 1; e.ext = 1; e.aluop = 3'b000;
    exp_q.push_back(e);
    runQueue(1'b0);
    asyncReset("sw_rst.reset");
`ifdef CU_RETIRE_COUNT_EN
    checkOutput("retire.after_mid_reset", retire_count, 32'd0);
`endif
    applyStimulus(OP_ADD, 1'b0, "add_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Moore/Mealy FSM that sequences the multi-cycle datapath: PC, instruction register, register file, ALU and data memory.
- Decodes the 6-bit Opcode held in the IR.
- Generates every datapath strobe, including RegWre, RegDst and DBDataSrc for the register file.
- Guarantees at most one register-file write and at most one memory write per instruction.

Parameters:
- OPW, 6, opcode width.
- ALUOPW, 3, ALUOp width.

Ports:
- CLK  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low; 0 forces state to IF
- Opcode  in  OPW  IR[31:26]; stable from end of IF
- zero  in  1  ALU result == 0
- PCWre  out  1  PC load enable
- IRWre  out  1  IR load enable
- RegWre  out  1  register-file write enable
- RegDst  out  2  00=$31, 01=rt, 10=rd
- WrRegDSrc  out  1  0=PC+4 (JAL), 1=DB bus
- DBDataSrc  out  1  0=ALU result, 1=memory data
- ALUSrcA  out  1  1=shamt
- ALUSrcB  out  1  1=extended immediate
- ExtSel  out  1  0=zero-extend, 1=sign-extend
- ALUOp  out  ALUOPW  000 add, 001 sub, 010 sll, 011 or, 100 and, 110 signed slt
- PCSrc  out  2  00=PC+4, 01=branch target, 10=rs (JR), 11=jump target
- mRD  out  1  data memory read
- mWR  out  1  data memory write
- state  out  3  current state, for debug

Behaviour:
- Opcodes:
  - ADD 000000, SUB 000001, ADDIU 000010
  - AND 010000, ANDI 010001, ORI 010010
  - SLL 011000, SLTI 011100
  - SW 100110, LW 100111
  - BEQ 110000, BNE 110001
  - J 111000, JR 111001, JAL 111010
  - HALT 111111
- States: IF=000, ID=001, EXE_LS=010, MEM=011, WB_LD=100, EXE_BR=101, EXE_AL=110, WB_AL=111.
- Only the state register is sequential. All outputs are combinational from state and Opcode.
- Reset: asynchronous. State becomes IF immediately, even mid-instruction. Reset outputs:
  - IRWre=1
  - PCWre=RegWre=mWR=mRD=0
  - PCSrc=00, RegDst=00, ALUOp=000
- IF: IRWre=1. Next state is ID.
- ID, by opcode:
  - J: PCWre=1, PCSrc=11, next IF.
  - JR: PCWre=1, PCSrc=10, next IF.
  - JAL: PCWre=1, PCSrc=11, RegWre=1, RegDst=00, WrRegDSrc=0, next IF.
  - HALT: stay in ID with PCWre=0 until Reset.
  - BEQ/BNE: next EXE_BR.
  - LW/SW: next EXE_LS.
  - Any other defined opcode: next EXE_AL.
  - Undefined opcode: NOP. PCWre=1, PCSrc=00, next IF.
- EXE_AL: ALU controls valid. Next WB_AL.
- WB_AL: RegWre=1, RegDst=10 for R-type (01 for immediate types), WrRegDSrc=1, DBDataSrc=0, PCWre=1, PCSrc=00. Next IF.
- EXE_BR: ALUOp=001, PCWre=1. PCSrc=01 if (BEQ and zero) or (BNE and not zero), else 00. Next IF.
- EXE_LS: ALUSrcB=1, ExtSel=1, ALUOp=000. Next MEM.
- MEM:
  - SW: mWR=1, PCWre=1, next IF.
  - LW: mRD=1, next WB_LD.
- WB_LD: RegWre=1, RegDst=01, DBDataSrc=1, WrRegDSrc=1, PCWre=1. Next IF.
- ALU controls are held constant from ID through the final state of each instruction:
  - ALUSrcB=1 for ADDIU, ANDI, ORI, SLTI, LW, SW.
  - ExtSel=0 for ANDI and ORI only.
  - ALUSrcA=1 for SLL only.
- Invariants:
  - PCWre is high for exactly one cycle per instruction, in the instruction's last state.
  - RegWre and mWR are never both high in the same cycle.
  - Latencies: ADD=4 cycles, LW=5, SW=4, BEQ=3, J=2.

Optional Feature:
- Macro: CU_RETIRE_COUNT_EN.
- When defined:
  - Adds output port RetireCount, 32 bits.
  - Reset clears it to 0.
  - It increments by 1 on every rising edge where PCWre=1, and wraps from 0xFFFFFFFF to 0.
- When undefined: the port and the counter are absent. All other behaviour is identical.

Decomposition:
- Package cpu_defs_pkg holds:
  - opcode constants
  - state encodings
  - ALUOp, PCSrc and RegDst code constants
- Sub-module cu_decode: combinational Opcode to static controls (ALUOp, ALUSrcA/B, ExtSel, RegDst class, instruction-class flags).
- The FSM and per-state strobe gating remain in multicycle_control_unit.

Test Plan:
- Reset low for 2 cycles, then high, Opcode=ADD -> state sequence 000, 001, 110, 111, 000. RegWre=1 only in WB_AL with RegDst=10. PCWre pulses once.
- Opcode=LW -> states IF, ID, EXE_LS, MEM, WB_LD. mRD=1 in MEM. In WB_LD: RegWre=1, DBDataSrc=1, RegDst=01.
- Opcode=BEQ with zero=1 -> EXE_BR gives PCSrc=01 and PCWre=1. Repeat with zero=0 -> PCSrc=00.
- Opcode=JAL -> 2-cycle instruction. In ID: RegWre=1, RegDst=00, WrRegDSrc=0, PCSrc=11.
- Opcode=HALT -> remains in ID for 10 cycles with PCWre=0. Reset low returns to IF asynchronously.
- Reset asserted during MEM of SW -> mWR drops immediately and state=000. With CU_RETIRE_COUNT_EN defined, RetireCount=0, then counts 3 after three ADDs.
